fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rapid_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rapid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rapid_pkg
// Description : Shared width, NOP encoding, fetch state enum and the
//               buffered-instruction record used by the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rapid_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous instruction buffer holding {pc, data} entries,
//               with push/pop/flush, full/empty flags and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rapid_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fetch_entry_t           i_entry,
    output fetch_entry_t           o_entry,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full buffer still accepts a push when the head leaves the same cycle.
    assign do_pop  = i_pop && (count != '0);
    assign do_push = i_push && ((count != DEPTH_C) || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem[wr_ptr] <= i_entry;
    end

    assign o_entry = mem[rd_ptr];
    assign o_full  = (count == DEPTH_C);
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with single outstanding request, redirect
//               flush and buffered decode hand-off. FETCH_MISALIGN_CHECK_EN
//               adds o_misaligned and request blocking on unaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rapid_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instruction,
    output logic [XLEN-1:0] o_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            o_misaligned,
`endif
    input  logic            i_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] target_pc;
    logic            started;
    logic            req_hold;
    logic            req;
    logic            grant;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] outstanding;
    fetch_entry_t    head;
    fetch_entry_t    new_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        misaligned <= 1'b0;
        else if (i_redirect) misaligned <= |i_redirect_pc[1:0];
    end

    assign target_pc    = i_redirect_pc;
    assign req_hold     = misaligned;
    assign o_misaligned = misaligned;
`else
    logic unused_pc_lsbs;

    assign target_pc      = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsbs = ^i_redirect_pc[1:0];
    assign req_hold       = 1'b0;
`endif

    // 'started' keeps the request low until the first edge after reset release.
    assign outstanding = (state == FETCH) ? '0 : CNT_W'(1);
    assign free_slots  = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign req   = started && (state == FETCH) && !fifo_full &&
                   (free_slots > outstanding) && !req_hold;
    assign grant = req && i_imem_gnt;
    assign push  = (state == WAIT) && i_imem_rvalid && !i_redirect;
    assign pop   = !fifo_empty && i_ready && !i_redirect;

    assign new_entry.pc   = fetch_pc - 32'd4;
    assign new_entry.data = i_imem_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            started  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            started  <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            FETCH:   if (grant) state_next = i_redirect ? DROP : WAIT;
            WAIT: begin
                if (i_imem_rvalid)   state_next = FETCH;
                else if (i_redirect) state_next = DROP;
            end
            DROP:    if (i_imem_rvalid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
        if (i_redirect)  fetch_pc_next = target_pc;
        else if (grant)  fetch_pc_next = fetch_pc + 32'd4;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_pop   (pop),
        .i_entry (new_entry),
        .o_entry (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign o_imem_req    = req;
    assign o_imem_addr   = fetch_pc;
    assign o_valid       = !fifo_empty;
    assign o_instruction = o_valid ? head.data : NOP_INSTR;
    assign o_pc          = o_valid ? head.pc   : '0;

endmodule
`default_nettype wire
